// File: rtl/fwd_hazard_unit.sv
// Operand forwarding / hazard detection for the pipelined core: tracks in-flight
// destinations and Tnew per stage. Define FWD_HAZARD_STATS_EN to enable event counters.

module fwd_hazard_port #(
  parameter int W     = 32,
  parameter int DEPTH = 3,
  parameter int TW    = 2,
  parameter int SW    = 4
) (
  input  logic [DEPTH-1:0]         vld,
  input  logic [DEPTH-1:0][4:0]    dst,
  input  logic [DEPTH-1:0][TW-1:0] tnew,
  input  logic [DEPTH-1:0][W-1:0]  stage_data,
  input  logic [4:0]               addr,
  input  logic [TW-1:0]            tuse,
  input  logic [W-1:0]             rf_data,
  output logic [W-1:0]             data,
  output logic [SW-1:0]            sel,
  output logic                     stall
);
  logic          hit;
  logic [TW-1:0] m_tnew;
  logic [SW-1:0] m_sel;
  logic [W-1:0]  m_data;

  // Walk oldest to youngest so the lowest-index match is the one that sticks.
  always_comb begin
    hit    = 1'b0;
    m_tnew = '0;
    m_sel  = '0;
    m_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (vld[k] && dst[k] == addr && addr != 5'd0) begin
        hit    = 1'b1;
        m_tnew = tnew[k];
        m_sel  = SW'(k + 1);
        m_data = stage_data[k];
      end
    end
  end

  // A not-yet-ready youngest match shadows any older ready copy.
  always_comb begin
    sel   = (hit && m_tnew == '0) ? m_sel : '0;
    data  = (hit && m_tnew == '0) ? m_data : rf_data;
    stall = hit && (m_tnew > tuse);
  end
endmodule

module fwd_hazard_unit #(
  parameter int W      = 32,
  parameter int DEPTH  = 3,
  parameter int NUM_RD = 2,
  parameter int TW     = 2,
  parameter int SW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_dst,
  input  logic [TW-1:0]        iss_tnew,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic [NUM_RD*5-1:0]  rd_addr,
  input  logic [NUM_RD*TW-1:0] rd_tuse,
  input  logic [NUM_RD*W-1:0]  rf_data,
  input  logic [DEPTH*W-1:0]   stage_data,
  output logic [NUM_RD*W-1:0]  fwd_data,
  output logic [NUM_RD*SW-1:0] fwd_sel,
  output logic                 stall_req,
  output logic [31:0]          stat_fwd,
  output logic [31:0]          stat_stall
);
  logic [DEPTH-1:0]         vld_pipe;
  logic [DEPTH-1:0][4:0]    dst_q;
  logic [DEPTH-1:0][TW-1:0] tnew_q;
  logic [DEPTH-1:0][W-1:0]  sd;
  logic [NUM_RD-1:0]        stall_vec;
  logic                     iss_ok;

  assign sd = stage_data;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    fwd_hazard_port #(.W(W), .DEPTH(DEPTH), .TW(TW), .SW(SW)) u_port (
      .vld        (vld_pipe),
      .dst        (dst_q),
      .tnew       (tnew_q),
      .stage_data (sd),
      .addr       (rd_addr[i*5 +: 5]),
      .tuse       (rd_tuse[i*TW +: TW]),
      .rf_data    (rf_data[i*W +: W]),
      .data       (fwd_data[i*W +: W]),
      .sel        (fwd_sel[i*SW +: SW]),
      .stall      (stall_vec[i])
    );
  end

  assign stall_req = |stall_vec;
  // Stalled issues are dropped; D re-presents them. r0 writes never need tracking.
  assign iss_ok = iss_valid && !stall_req && iss_dst != 5'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      dst_q    <= '0;
      tnew_q   <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else if (!freeze) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        vld_pipe[k] <= vld_pipe[k-1];
        dst_q[k]    <= dst_q[k-1];
        tnew_q[k]   <= (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
      end
      vld_pipe[0] <= iss_ok;
      dst_q[0]    <= iss_dst;
      tnew_q[0]   <= iss_tnew;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] fwd_cnt, stall_cnt, nfwd;

  always_comb begin
    nfwd = '0;
    for (int i = 0; i < NUM_RD; i++)
      if (fwd_sel[i*SW +: SW] != '0) nfwd = nfwd + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (!freeze)  fwd_cnt   <= fwd_cnt + nfwd;
      if (stall_req) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stat_fwd   = fwd_cnt;
  assign stat_stall = stall_cnt;
`else
  assign stat_fwd   = '0;
  assign stat_stall = '0;
`endif
endmodule
